// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: decodes RV32I/M OP and OP-IMM instructions into operands and
// op codes for an external ALU32Bit. It holds those operands for a per-class number of
// cycles, then captures the ALU output and applies the RISC-V divide corner-case fixes.
module alu_issue_sequencer #(
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam int MAX_AM  = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
    localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_SLT    = 5'b00011;
    localparam logic [4:0] OP_SLTU   = 5'b00101;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_OR     = 5'b01000;
    localparam logic [4:0] OP_SLL    = 5'b01010;
    localparam logic [4:0] OP_SRL    = 5'b01011;
    localparam logic [4:0] OP_SRA    = 5'b01101;
    localparam logic [4:0] OP_MUL    = 5'b01110;
    localparam logic [4:0] OP_MULH   = 5'b01111;
    localparam logic [4:0] OP_MULHU  = 5'b10000;
    localparam logic [4:0] OP_MULHSU = 5'b10001;
    localparam logic [4:0] OP_DIV    = 5'b10010;
    localparam logic [4:0] OP_DIVU   = 5'b10011;
    localparam logic [4:0] OP_REM    = 5'b10100;
    localparam logic [4:0] OP_REMU   = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    logic             dec_legal;
    logic [4:0]       dec_op;
    logic [31:0]      dec_b;
    logic [CNT_W-1:0] dec_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [31:0] imm_sext;
    logic [31:0] shamt_imm;
    logic [31:0] shamt_reg;
    logic        unused_rs1_field;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_sext  = {{20{instr[31]}}, instr[31:20]};
    assign shamt_imm = {27'b0, instr[24:20]};
    assign shamt_reg = {27'b0, rs2_data[4:0]};
    // The rs1 index is resolved upstream; only its data arrives here.
    assign unused_rs1_field = ^instr[19:15];

    // RISC-V results for divide-by-zero and signed overflow, which ALU32Bit does not produce.
    function automatic logic [31:0] fix_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] r);
        logic div0;
        logic ovf;
        div0 = (b == 32'h0);
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        fix_result = r;
        case (op)
            OP_DIV: begin
                if (div0)     fix_result = 32'hFFFF_FFFF;
                else if (ovf) fix_result = 32'h8000_0000;
            end
            OP_DIVU: if (div0) fix_result = 32'hFFFF_FFFF;
            OP_REM: begin
                if (div0)     fix_result = a;
                else if (ovf) fix_result = 32'h0;
            end
            OP_REMU: if (div0) fix_result = a;
            default: fix_result = r;
        endcase
    endfunction

    // Hold budget per op class; the counter is loaded with budget-1.
    function automatic logic [CNT_W-1:0] class_cnt(input logic [4:0] op);
        if (op >= OP_DIV)      class_cnt = DIV_CNT;
        else if (op >= OP_MUL) class_cnt = MUL_CNT;
        else                   class_cnt = ALU_CNT;
    endfunction

    // Instruction decode into op code, B operand and legality.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_ADD;
        dec_b     = rs2_data;
        if (opcode == OPC_OP) begin
            case (funct7)
                7'b0000000: begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000: dec_op = OP_ADD;
                        3'b001: begin dec_op = OP_SLL; dec_b = shamt_reg; end
                        3'b010: dec_op = OP_SLT;
                        3'b011: dec_op = OP_SLTU;
                        3'b101: begin dec_op = OP_SRL; dec_b = shamt_reg; end
                        3'b110: dec_op = OP_OR;
                        3'b111: dec_op = OP_AND;
                        default: dec_legal = 1'b0;
                    endcase
                end
                7'b0100000: begin
                    case (funct3)
                        3'b000: begin dec_legal = 1'b1; dec_op = OP_SUB; end
                        3'b101: begin dec_legal = 1'b1; dec_op = OP_SRA; dec_b = shamt_reg; end
                        default: dec_legal = 1'b0;
                    endcase
                end
                7'b0000001: begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_op = OP_MUL;
                        3'b001:  dec_op = OP_MULH;
                        3'b010:  dec_op = OP_MULHSU;
                        3'b011:  dec_op = OP_MULHU;
                        3'b100:  dec_op = OP_DIV;
                        3'b101:  dec_op = OP_DIVU;
                        3'b110:  dec_op = OP_REM;
                        default: dec_op = OP_REMU;
                    endcase
                end
                default: dec_legal = 1'b0;
            endcase
        end else if (opcode == OPC_IMM) begin
            dec_b = imm_sext;
            case (funct3)
                3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD; end
                3'b010: begin dec_legal = 1'b1; dec_op = OP_SLT; end
                3'b011: begin dec_legal = 1'b1; dec_op = OP_SLTU; end
                3'b110: begin dec_legal = 1'b1; dec_op = OP_OR; end
                3'b111: begin dec_legal = 1'b1; dec_op = OP_AND; end
                3'b001: begin
                    dec_b = shamt_imm;
                    if (funct7 == 7'b0000000) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SLL;
                    end
                end
                3'b101: begin
                    dec_b = shamt_imm;
                    if (funct7 == 7'b0000000) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRL;
                    end else if (funct7 == 7'b0100000) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRA;
                    end
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    assign dec_cnt   = class_cnt(dec_op);
    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: accept, hold for the class budget, then wait for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = dec_legal ? EXEC : DONE;
            EXEC: if (cnt == '0) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/result registers and hold counter; ALU operands change only on a legal accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_rd <= instr[11:7];
            if (dec_legal) begin
                alu_a       <= rs1_data;
                alu_b       <= dec_b;
                alu_op      <= dec_op;
                cnt         <= dec_cnt;
                out_illegal <= 1'b0;
            end else begin
                out_illegal <= 1'b1;
                out_result  <= '0;
            end
        end else if (state == EXEC) begin
            if (cnt == '0) out_result <= fix_result(alu_op, alu_a, alu_b, alu_result);
            else           cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer: a vector table with hand-computed ALU
// responses and expected results, plus backpressure and reset-abort sequences.
module tb_alu_issue_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    alu_issue_sequencer #(.ALU_LAT(1), .MUL_LAT(2), .DIV_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] drv;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        int          lat;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [31:0] ins, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] drv, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] op, input int lat,
                           input logic [31:0] res, input logic [4:0] rd, input logic ill);
        vec_t v;
        v.name = name; v.instr = ins; v.rs1 = r1; v.rs2 = r2; v.drv = drv;
        v.a = a; v.b = b; v.op = op; v.lat = lat; v.res = res; v.rd = rd; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int cycles;
        chk({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        instr      = v.instr;
        rs1_data   = v.rs1;
        rs2_data   = v.rs2;
        alu_result = v.drv;
        out_ready  = 1'b0;
        tick();
        in_valid = 1'b0;
        instr    = 32'hFFFF_FFFF;
        rs1_data = $urandom;
        rs2_data = $urandom;
        chk({v.name, ".alu_a"}, alu_a, v.a);
        chk({v.name, ".alu_b"}, alu_b, v.b);
        chk({v.name, ".alu_op"}, 32'(alu_op), 32'(v.op));
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        chk({v.name, ".latency"}, 32'(cycles), 32'(v.lat));
        chk({v.name, ".out_result"}, out_result, v.res);
        chk({v.name, ".out_rd"}, 32'(out_rd), 32'(v.rd));
        chk({v.name, ".out_illegal"}, 32'(out_illegal), 32'(v.ill));
        chk({v.name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        chk({v.name, ".alu_a_held"}, alu_a, v.a);
        chk({v.name, ".alu_op_held"}, 32'(alu_op), 32'(v.op));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({v.name, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        in_valid = 0; instr = 0; rs1_data = 0; rs2_data = 0; alu_result = 0; out_ready = 0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_result", out_result, 32'd0);
        chk("rst.alu_a", alu_a, 32'd0);
        chk("rst.alu_op", 32'(alu_op), 32'd0);
        chk("rst.out_illegal", 32'(out_illegal), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel.in_ready", 32'(in_ready), 32'd1);

        add_vec("add",    r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 32'd12,
                32'd5, 32'd7, 5'b00000, 1, 32'd12, 5'd3, 1'b0);
        add_vec("srai",   i_type(12'h404, 5'd1, 3'd5, 5'd5, 7'b0010011), 32'hF000_0000, 32'h1234_5678,
                32'hFF00_0000, 32'hF000_0000, 32'd4, 5'b01101, 1, 32'hFF00_0000, 5'd5, 1'b0);
        add_vec("sll",    r_type(7'h00, 5'd2, 5'd1, 3'd1, 5'd6), 32'd3, 32'h21, 32'd6,
                32'd3, 32'd1, 5'b01010, 1, 32'd6, 5'd6, 1'b0);
        add_vec("div0",   r_type(7'h01, 5'd2, 5'd1, 3'd4, 5'd7), 32'd7, 32'd0, 32'd0,
                32'd7, 32'd0, 5'b10010, 4, 32'hFFFF_FFFF, 5'd7, 1'b0);
        add_vec("remu0",  r_type(7'h01, 5'd2, 5'd1, 3'd7, 5'd8), 32'd7, 32'd0, 32'd0,
                32'd7, 32'd0, 5'b10101, 4, 32'd7, 5'd8, 1'b0);
        add_vec("divovf", r_type(7'h01, 5'd2, 5'd1, 3'd4, 5'd9), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
                32'h8000_0000, 32'hFFFF_FFFF, 5'b10010, 4, 32'h8000_0000, 5'd9, 1'b0);
        add_vec("removf", r_type(7'h01, 5'd2, 5'd1, 3'd6, 5'd9), 32'h8000_0000, 32'hFFFF_FFFF, 32'd5,
                32'h8000_0000, 32'hFFFF_FFFF, 5'b10100, 4, 32'd0, 5'd9, 1'b0);
        add_vec("mul",    r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd10), 32'h1_0000, 32'h1_0000, 32'd0,
                32'h1_0000, 32'h1_0000, 5'b01110, 2, 32'd0, 5'd10, 1'b0);
        add_vec("mulhu",  r_type(7'h01, 5'd2, 5'd1, 3'd3, 5'd11), 32'h1_0000, 32'h1_0000, 32'd1,
                32'h1_0000, 32'h1_0000, 5'b10000, 2, 32'd1, 5'd11, 1'b0);
        add_vec("xor",    r_type(7'h00, 5'd2, 5'd1, 3'd4, 5'd12), 32'd55, 32'd66, 32'd1234,
                32'h1_0000, 32'h1_0000, 5'b10000, 0, 32'd0, 5'd12, 1'b1);
        add_vec("addi",   i_type(12'hFFF, 5'd1, 3'd0, 5'd13, 7'b0010011), 32'd10, 32'd99, 32'd9,
                32'd10, 32'hFFFF_FFFF, 5'b00000, 1, 32'd9, 5'd13, 1'b0);
        add_vec("sub",    r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd14), 32'd10, 32'd3, 32'd7,
                32'd10, 32'd3, 5'b00001, 1, 32'd7, 5'd14, 1'b0);
        add_vec("divu",   r_type(7'h01, 5'd2, 5'd1, 3'd5, 5'd15), 32'd20, 32'd3, 32'd6,
                32'd20, 32'd3, 5'b10011, 4, 32'd6, 5'd15, 1'b0);
        add_vec("load",   i_type(12'h000, 5'd1, 3'd2, 5'd16, 7'b0000011), 32'd77, 32'd88, 32'd5,
                32'd20, 32'd3, 5'b10011, 0, 32'd0, 5'd16, 1'b1);
        add_vec("slli_f7", i_type(12'h023, 5'd1, 3'd1, 5'd17, 7'b0010011), 32'd77, 32'd88, 32'd5,
                32'd20, 32'd3, 5'b10011, 0, 32'd0, 5'd17, 1'b1);
        add_vec("srl",    r_type(7'h00, 5'd2, 5'd1, 3'd5, 5'd18), 32'h80, 32'hFFFF_FFE3, 32'h10,
                32'h80, 32'd3, 5'b01011, 1, 32'h10, 5'd18, 1'b0);
        add_vec("sltu",   r_type(7'h00, 5'd2, 5'd1, 3'd3, 5'd19), 32'd1, 32'd2, 32'd1,
                32'd1, 32'd2, 5'b00101, 1, 32'd1, 5'd19, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held five cycles, new requests ignored meanwhile.
        in_valid = 1'b1; instr = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd20);
        rs1_data = 32'd100; rs2_data = 32'd23; alu_result = 32'd123; out_ready = 1'b0;
        tick();
        instr = r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd21); rs1_data = 32'd999;
        tick();
        chk("bp.out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_result", out_result, 32'd123);
            chk("bp.hold_rd", 32'(out_rd), 32'd20);
            chk("bp.hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp.hold_alu_a", alu_a, 32'd100);
            chk("bp.hold_alu_op", 32'(alu_op), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.done_valid", 32'(out_valid), 32'd0);
        chk("bp.done_in_ready", 32'(in_ready), 32'd1);
        chk("bp.alu_a_after", alu_a, 32'd100);

        // Reset during the second EXEC cycle of a DIV aborts it silently.
        in_valid = 1'b1; instr = r_type(7'h01, 5'd2, 5'd1, 3'd4, 5'd22);
        rs1_data = 32'd50; rs2_data = 32'd5; alu_result = 32'd10;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rstmid.out_valid", 32'(out_valid), 32'd0);
        chk("rstmid.in_ready", 32'(in_ready), 32'd0);
        chk("rstmid.alu_a", alu_a, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rstmid.no_valid", 32'(out_valid), 32'd0);
        end
        chk("rstmid.in_ready_after", 32'(in_ready), 32'd1);
        chk("rstmid.out_result", out_result, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
